clic_timer_src: RTL and testbench

Programmable periodic/one-shot timer that acts as an interrupt source for the n-level CLIC. The core configures it through CSR writes. It raises a level `pend` request towards one CLIC interrupt line and holds it until the CLIC signals `taken`, which is when the core vectors to that interrupt. It sits beside the CLIC in `top_n_clic` and is the initiator on the CLIC's pend/take interface.

---
 rtl/clic_timer_src.sv | 161 ++++++++++++++++
 tb/tb_clic_timer_src.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/clic_timer_src.sv
// Programmable periodic / one-shot timer acting as a level interrupt source
// for one CLIC line.
//   clk         system clock, all state on the rising edge
//   reset       asynchronous active-low reset
//   csr_enable  one-cycle CSR write strobe
//   csr_addr    CSR address (CTRL @CsrAddr, CMP @+1, CNT @+2)
//   csr_wdata   CSR write data
//   csr_out     combinational read of the addressed register, 0 if unmapped
//   taken       one-cycle pulse from the CLIC when it vectors to this line
//   pend        registered interrupt request towards the CLIC
module clic_timer_src #(
   parameter logic [11:0] CsrAddr    = 12'h400,
   parameter int unsigned TimerWidth = 32,
   parameter int unsigned PrescWidth = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        csr_enable,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_wdata,
   output logic [31:0] csr_out,
   input  logic        taken,
   output logic        pend
);

   localparam int unsigned PcntWidth = 2 ** PrescWidth;
   localparam logic [11:0] AddrCtrl  = CsrAddr;
   localparam logic [11:0] AddrCmp   = CsrAddr + 12'd1;
   localparam logic [11:0] AddrCnt   = CsrAddr + 12'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIRE = 2'd2
   } state_e;

   state_e                  state_q, state_d;
   logic                    periodic_q, periodic_d;
   logic [PrescWidth-1:0]   presc_q, presc_d;
   logic                    overrun_q, overrun_d;
   logic [TimerWidth-1:0]   cmp_q, cmp_d;
   logic [TimerWidth-1:0]   cnt_q, cnt_d;
   logic [PcntWidth-1:0]    pcnt_q, pcnt_d;
   logic                    pend_q, pend_d;

   logic ctrl_wr, cmp_wr, cnt_wr;
   logic running, tick, match;
   logic unused_wdata;

   assign ctrl_wr = csr_enable && (csr_addr == AddrCtrl);
   assign cmp_wr  = csr_enable && (csr_addr == AddrCmp);
   assign cnt_wr  = csr_enable && (csr_addr == AddrCnt);

   // The en bit is the FSM itself: any non-idle state counts.
   assign running = (state_q != ST_IDLE);
   assign tick    = running &&
                    (pcnt_q == ((PcntWidth'(1) << presc_q) - PcntWidth'(1)));
   // A CTRL or CNT write in a tick cycle suppresses that cycle's evaluation.
   assign match   = tick && !ctrl_wr && !cnt_wr && (cnt_q == cmp_q);

   assign pend         = pend_q;
   assign unused_wdata = ^csr_wdata;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (ctrl_wr) begin
         state_d = csr_wdata[0] ? ST_RUN : ST_IDLE;
      end else if (match) begin
         state_d = periodic_q ? ST_FIRE : ST_IDLE;
      end else if (state_q == ST_FIRE) begin
         state_d = ST_RUN;
      end
   end

   // Datapath next values
   always_comb begin
      periodic_d = periodic_q;
      presc_d    = presc_q;
      overrun_d  = overrun_q;
      cmp_d      = cmp_q;
      cnt_d      = cnt_q;
      pcnt_d     = pcnt_q;
      pend_d     = pend_q;

      if (ctrl_wr) begin
         periodic_d = csr_wdata[1];
         presc_d    = csr_wdata[4 +: PrescWidth];
         overrun_d  = 1'b0;
         pcnt_d     = '0;
      end else if (running) begin
         pcnt_d = tick ? '0 : pcnt_q + PcntWidth'(1);
      end

      if (cmp_wr) begin
         cmp_d = csr_wdata[TimerWidth-1:0];
      end

      if (cnt_wr) begin
         cnt_d = csr_wdata[TimerWidth-1:0];
      end else if (tick && !ctrl_wr) begin
         cnt_d = match ? '0 : cnt_q + TimerWidth'(1);
      end

      // A match wins over a same-cycle taken; overrun only if nobody took it.
      if (match) begin
         pend_d = 1'b1;
         if (pend_q && !taken) begin
            overrun_d = 1'b1;
         end
      end else if (taken) begin
         pend_d = 1'b0;
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         periodic_q <= 1'b0;
         presc_q    <= '0;
         overrun_q  <= 1'b0;
         cmp_q      <= '0;
         cnt_q      <= '0;
         pcnt_q     <= '0;
         pend_q     <= 1'b0;
      end else begin
         periodic_q <= periodic_d;
         presc_q    <= presc_d;
         overrun_q  <= overrun_d;
         cmp_q      <= cmp_d;
         cnt_q      <= cnt_d;
         pcnt_q     <= pcnt_d;
         pend_q     <= pend_d;
      end
   end

   // Combinational CSR read
   always_comb begin
      csr_out = '0;
      if (csr_addr == AddrCtrl) begin
         csr_out[0]              = running;
         csr_out[1]              = periodic_q;
         csr_out[4 +: PrescWidth] = presc_q;
         csr_out[8]              = overrun_q;
      end else if (csr_addr == AddrCmp) begin
         csr_out[TimerWidth-1:0] = cmp_q;
      end else if (csr_addr == AddrCnt) begin
         csr_out[TimerWidth-1:0] = cnt_q;
      end
   end

endmodule

// File: tb/tb_clic_timer_src.sv
// Scoreboard bench for clic_timer_src: every cycle the stimulus process
// pushes the expected pend / csr_out from a behavioural timer model, and a
// monitor on the falling edge pops and compares.
module tb_clic_timer_src;

   localparam logic [11:0] A_CTRL = 12'h400;
   localparam logic [11:0] A_CMP  = 12'h401;
   localparam logic [11:0] A_CNT  = 12'h402;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        csr_enable = 1'b0;
   logic [11:0] csr_addr = 12'h0;
   logic [31:0] csr_wdata = 32'h0;
   logic [31:0] csr_out;
   logic        taken = 1'b0;
   logic        pend;

   int checks = 0;
   int errors = 0;
   int ncyc   = 0;

   typedef struct {
      logic        pend;
      logic [31:0] out;
      logic [11:0] addr;
      int          cyc;
   } exp_t;

   exp_t sb_q[$];

   // Behavioural model state
   bit          m_en, m_per, m_ovr, m_pend;
   bit [3:0]    m_presc;
   bit [31:0]   m_cmp, m_cnt;
   int          m_pcnt;

   clic_timer_src dut (
      .clk       (clk),
      .reset     (reset),
      .csr_enable(csr_enable),
      .csr_addr  (csr_addr),
      .csr_wdata (csr_wdata),
      .csr_out   (csr_out),
      .taken     (taken),
      .pend      (pend)
   );

   always #5 clk = ~clk;

   task automatic m_reset();
      m_en = 0; m_per = 0; m_ovr = 0; m_pend = 0;
      m_presc = 0; m_cmp = 0; m_cnt = 0; m_pcnt = 0;
   endtask

   function automatic logic [31:0] m_read(input logic [11:0] a);
      case (a)
         A_CTRL:  return {23'd0, m_ovr, m_presc, 2'b00, m_per, m_en};
         A_CMP:   return m_cmp;
         A_CNT:   return m_cnt;
         default: return 32'd0;
      endcase
   endfunction

   // One clock edge of the timer, described from its register-level rules.
   task automatic m_step(input bit we, input logic [11:0] a,
                         input logic [31:0] d, input bit tk);
      bit tick, matched;
      tick    = m_en && (m_pcnt == (1 << m_presc) - 1);
      matched = 0;
      if (we && a == A_CTRL) begin
         m_en = d[0]; m_per = d[1]; m_presc = d[7:4];
         m_ovr = 0; m_pcnt = 0;
      end else begin
         if (m_en) m_pcnt = tick ? 0 : m_pcnt + 1;
         if (we && a == A_CNT) m_cnt = d;
         else if (tick) begin
            if (m_cnt == m_cmp) matched = 1;
            else m_cnt = m_cnt + 1;
         end
      end
      if (we && a == A_CMP) m_cmp = d;
      if (matched) begin
         m_cnt = 0;
         if (m_pend && !tk) m_ovr = 1;
         m_pend = 1;
         if (!m_per) m_en = 0;
      end else if (tk) begin
         m_pend = 0;
      end
   endtask

   task automatic cyc(input bit we, input logic [11:0] a, input logic [31:0] d,
                      input bit tk, input bit rst_act);
      exp_t e;
      @(posedge clk); #1;
      reset = !rst_act; csr_enable = we; csr_addr = a; csr_wdata = d; taken = tk;
      if (rst_act) m_reset();
      e.pend = m_pend; e.out = m_read(a); e.addr = a; e.cyc = ncyc;
      ncyc++;
      sb_q.push_back(e);
      if (!rst_act) m_step(we, a, d, tk);
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      cyc(1, a, d, 0, 0);
   endtask

   // Idle cycles reading one address; optionally take pend whenever it is high.
   task automatic run(input int n, input logic [11:0] a, input bit auto_take);
      for (int i = 0; i < n; i++) cyc(0, a, 32'd0, auto_take && m_pend, 0);
   endtask

   // Monitor: compares every presented cycle against the scoreboard.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         checks++;
         if (pend !== e.pend) begin
            errors++;
            $display("FAIL pend cyc=%0d got=%0b exp=%0b", e.cyc, pend, e.pend);
         end
         checks++;
         if (csr_out !== e.out) begin
            errors++;
            $display("FAIL csr_out cyc=%0d addr=%h got=%h exp=%h",
                     e.cyc, e.addr, csr_out, e.out);
         end
      end
   end

   initial begin
      logic [31:0] d;
      logic [11:0] a;
      int          sel;

      // Reset, then force pend high mid-run and reset again
      cyc(0, A_CTRL, 0, 0, 1);
      wr(A_CMP, 32'd0);
      wr(A_CTRL, 32'h3);
      run(3, A_CNT, 0);
      cyc(0, A_CTRL, 0, 0, 1);
      cyc(0, A_CTRL, 0, 0, 1);
      for (int i = 0; i < 100; i++) cyc(0, 12'(A_CTRL + 12'(i % 4)), 0, 0, 0);

      // Periodic fire, CMP=3, presc=0, take each request
      wr(A_CMP, 32'd3);
      wr(A_CTRL, 32'h3);
      run(20, A_CNT, 1);

      // Prescaler + one-shot: CMP=1, presc=2
      wr(A_CTRL, 32'h0);
      wr(A_CNT, 32'h0);
      wr(A_CMP, 32'd1);
      wr(A_CTRL, 32'h21);
      run(12, A_CNT, 0);
      run(4, A_CTRL, 1);
      run(4, A_CNT, 0);

      // Overrun: CMP=0, never take; then clear by CTRL write
      wr(A_CMP, 32'd0);
      wr(A_CTRL, 32'h3);
      run(5, A_CTRL, 0);
      wr(A_CTRL, 32'h3);
      run(2, A_CTRL, 0);

      // Take coinciding with a match (every cycle matches here)
      cyc(0, A_CTRL, 0, 1, 0);
      run(3, A_CTRL, 0);

      // Collision: CNT=2 written in a tick cycle with CMP=2, then unmapped writes
      wr(A_CTRL, 32'h0);
      cyc(0, A_CTRL, 0, 1, 0);
      wr(A_CNT, 32'h0);
      wr(A_CMP, 32'd2);
      wr(A_CTRL, 32'h3);
      run(2, A_CNT, 0);
      wr(A_CNT, 32'd2);
      run(4, A_CNT, 1);
      wr(12'h403, 32'hFFFF_FFFF);
      wr(12'h3FF, 32'h0000_0123);
      run(2, 12'h403, 0);

      // Wrap: CNT written above CMP counts through zero first
      wr(A_CMP, 32'd1);
      wr(A_CNT, 32'hFFFF_FFFE);
      run(6, A_CNT, 1);

      // Randomized phase
      for (int i = 0; i < 3000; i++) begin
         sel = $urandom_range(0, 4);
         case (sel)
            0: a = A_CTRL;
            1: a = A_CMP;
            2: a = A_CNT;
            3: a = 12'h403;
            default: a = 12'h3FF;
         endcase
         d = $urandom;
         if (a == A_CTRL) begin
            d[7:4] = 4'($urandom_range(0, 2));
            d[0]   = ($urandom_range(0, 3) != 0);
         end else if (a == A_CMP) begin
            d = 32'($urandom_range(0, 6));
         end else if (a == A_CNT) begin
            d = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 8));
         end
         cyc($urandom_range(0, 99) < 8, a, d,
             m_pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0),
             $urandom_range(0, 499) == 0);
      end

      @(negedge clk); #1;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
